// File: rtl/palm_run_locator.sv
// palm_run_locator
//   Finds, per frame, the first horizontal run of hand pixels (raster order)
//   that is at least MIN_WIDTH wide.  Short gaps of up to MAX_GAP background
//   pixels are tolerated inside a run.  A run never spans two rows.
//
// Ports
//   clk, rst (async, active-low)
//   vsync            one-cycle frame start; re-arms the search
//   de_t             pixel valid; low cycles are stalls
//   object_image     hand pixel when 1 (qualified by de_t)
//   TESTING_SWITCH   selects palm_height_test as the reported height
//   palm_height_test manual height
//   start/end_of_palm_r/c, palm_width, palm_height   locked run geometry
//   palm_valid       high from lock until next vsync
//   palm_lock        one-cycle pulse on lock
//   frame_done       one-cycle pulse after the last pixel of the frame
//   dbg_state        current FSM state (IDLE=0, SCAN=1, LOCKED=2, DONE=3)
//
// Handshake: a pixel is accepted on a rising clk edge where de_t=1 and vsync=0
// while the FSM is in SCAN or LOCKED; there is no backpressure.
module palm_run_locator #(
  parameter int IMG_W     = 120,
  parameter int IMG_H     = 160,
  parameter int CW        = 10,
  parameter int MIN_WIDTH = 18,
  parameter int MAX_GAP   = 0,
  parameter int H_MUL     = 3,
  parameter int H_SHIFT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          de_t,
  input  logic          object_image,
  input  logic          TESTING_SWITCH,
  input  logic [CW-1:0] palm_height_test,
  output logic [CW-1:0] start_of_palm_r,
  output logic [CW-1:0] start_of_palm_c,
  output logic [CW-1:0] end_of_palm_r,
  output logic [CW-1:0] end_of_palm_c,
  output logic [CW-1:0] palm_width,
  output logic [CW-1:0] palm_height,
  output logic          palm_valid,
  output logic          palm_lock,
  output logic          frame_done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, LOCKED = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] MIN_W_V   = CW'(MIN_WIDTH);
  localparam logic [CW:0]   MAX_GAP_V = (CW + 1)'(MAX_GAP);
  localparam logic [CW+7:0] H_MUL_V   = (CW + 8)'(H_MUL);

  state_t        state;
  logic [CW-1:0] row, col;
  logic          run_open;
  logic [CW-1:0] rs_c, re_c, run_row, gap;

  // Next run-tracker state for the pixel currently presented.
  logic          n_open, term;
  logic [CW-1:0] n_rs, n_re, n_row, n_gap;
  logic [CW:0]   gap_inc;
  logic          last_col, last_row;
  logic [CW-1:0] t_width, calc_h;
  logic [CW+7:0] prod, shifted;
  logic          wide;

  assign dbg_state = state;
  assign last_col  = (col == LAST_COL);
  assign last_row  = (row == LAST_ROW);
  assign gap_inc   = {1'b0, gap} + (CW + 1)'(1);

  always_comb begin
    n_open = run_open;
    n_rs   = rs_c;
    n_re   = re_c;
    n_row  = run_row;
    n_gap  = gap;
    term   = 1'b0;
    if (object_image) begin
      if (!run_open) begin
        n_rs  = col;
        n_row = row;
      end
      n_open = 1'b1;
      n_re   = col;
      n_gap  = '0;
    end else if (run_open) begin
      // re_c stays at the last object pixel, so trailing gap never counts.
      if (gap_inc > MAX_GAP_V) term = 1'b1;
      else                     n_gap = gap_inc[CW-1:0];
    end
    // Row end closes whatever is still open, including a run opened right here.
    if (last_col && n_open) term = 1'b1;
    if (term) begin
      n_open = 1'b0;
      n_gap  = '0;
    end
  end

  assign t_width = n_re - n_rs + ONE;
  assign wide    = (t_width >= MIN_W_V);
  assign prod    = {8'd0, t_width} * H_MUL_V;
  assign shifted = prod >> H_SHIFT;
  assign calc_h  = TESTING_SWITCH ? palm_height_test
                 : ((|shifted[CW+7:CW]) ? '1 : shifted[CW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      row             <= '0;
      col             <= '0;
      run_open        <= 1'b0;
      rs_c            <= '0;
      re_c            <= '0;
      run_row         <= '0;
      gap             <= '0;
      start_of_palm_r <= '0;
      start_of_palm_c <= '0;
      end_of_palm_r   <= '0;
      end_of_palm_c   <= '0;
      palm_width      <= '0;
      palm_height     <= '0;
      palm_valid      <= 1'b0;
      palm_lock       <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      palm_lock  <= 1'b0;
      frame_done <= 1'b0;
      if (vsync) begin
        // Geometry outputs intentionally keep the previous frame's values.
        row        <= '0;
        col        <= '0;
        run_open   <= 1'b0;
        rs_c       <= '0;
        re_c       <= '0;
        run_row    <= '0;
        gap        <= '0;
        palm_valid <= 1'b0;
        state      <= SCAN;
      end else if (de_t && (state == SCAN || state == LOCKED)) begin
        if (last_col) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
        if (state == SCAN) begin
          run_open <= n_open;
          rs_c     <= n_rs;
          re_c     <= n_re;
          run_row  <= n_row;
          gap      <= n_gap;
          if (term && wide) begin
            start_of_palm_r <= n_row;
            start_of_palm_c <= n_rs;
            end_of_palm_r   <= n_row;
            end_of_palm_c   <= n_re;
            palm_width      <= t_width;
            palm_height     <= calc_h;
            palm_lock       <= 1'b1;
            palm_valid      <= 1'b1;
            state           <= LOCKED;
          end
        end
        // Last pixel of the frame overrides a same-cycle lock transition.
        if (last_col && last_row) begin
          row        <= '0;
          frame_done <= 1'b1;
          state      <= DONE;
        end
      end
    end
  end

endmodule
